// File: rtl/packet_demux.sv
// packet_demux: routes whole packets from one upstream stream to one of
// N_OUT downstream ports, each backed by a one-entry output register.
// The destination is latched on the first beat and held until the last beat.
// Packets aimed at a nonexistent port are swallowed and counted.
module packet_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [WIDTH-1:0]       up_data,
    input  logic                   up_last,
    input  logic [SEL_W-1:0]       up_sel,
    output logic [N_OUT-1:0]       down_valid,
    input  logic [N_OUT-1:0]       down_ready,
    output logic [N_OUT*WIDTH-1:0] down_data,
    output logic [N_OUT-1:0]       down_last,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_route;
    logic [CNT_W-1:0]   r_drop;

    logic [SEL_W-1:0]   w_dst;
    logic               w_dst_ok;
    logic               w_accept;
    logic [N_OUT-1:0]   w_hit;
    logic [N_OUT-1:0]   w_port_rdy;
    logic [N_OUT-1:0]   w_load;
    logic [N_OUT-1:0]   w_full;

    // Destination follows up_sel between packets and the latched route mid-packet.
    assign w_dst    = (r_state == ROUTE) ? r_route : up_sel;
    assign w_dst_ok = ({1'b0, w_dst} < (SEL_W + 1)'(N_OUT));

    // Invalid destinations are always ready so the packet can be discarded.
    assign up_ready = w_dst_ok ? |(w_hit & w_port_rdy) : 1'b1;
    assign w_accept = up_valid & up_ready;

    assign busy       = (r_state == ROUTE);
    assign drop_count = r_drop;
    assign down_valid = w_full;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_port
            logic             r_full;
            logic [WIDTH-1:0] r_data;
            logic             r_last;

            assign w_hit[gi]      = (w_dst == SEL_W'(gi));
            // A port can take a beat if empty or if it drains this same cycle.
            assign w_port_rdy[gi] = !r_full | down_ready[gi];
            assign w_load[gi]     = w_accept & w_dst_ok & w_hit[gi];
            assign w_full[gi]     = r_full;
            assign down_data[gi*WIDTH +: WIDTH] = r_data;
            assign down_last[gi]  = r_last;

            // Holding register: load wins over drain, so full stays set on overlap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full <= 1'b0;
                    r_data <= '0;
                    r_last <= 1'b0;
                end else if (w_load[gi]) begin
                    r_full <= 1'b1;
                    r_data <= up_data;
                    r_last <= up_last;
                end else if (down_ready[gi]) begin
                    r_full <= 1'b0;
                end
            end
        end
    endgenerate

    // Packet-lock FSM: latch the route on the first beat, release on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_route <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    r_route <= up_sel;
                    r_state <= up_last ? IDLE : ROUTE;
                end
                ROUTE: begin
                    if (up_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating count of beats discarded for an out-of-range destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (up_valid && !w_dst_ok && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_packet_demux.sv
// Bench for packet_demux: a scoreboard of expected beats per port, filled
// when a beat is accepted upstream and consumed when the port drains.
// A second instance with N_OUT=3, CNT_W=4 exercises the drop path.
module tb_packet_demux;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main instance (4 ports)
    logic        up_valid, up_ready, up_last, busy;
    logic [7:0]  up_data;
    logic [1:0]  up_sel;
    logic [3:0]  down_valid, down_ready, down_last;
    logic [31:0] down_data;
    logic [15:0] drop_count;

    // Drop instance (3 ports, 4-bit counter)
    logic        d_valid, d_ready, d_last, d_busy;
    logic [7:0]  d_data;
    logic [1:0]  d_sel;
    logic [2:0]  d_down_valid, d_down_ready, d_down_last;
    logic [23:0] d_down_data;
    logic [3:0]  d_drop_count;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic       m_in_pkt;
    logic [1:0] m_route;
    logic       m_acc;
    logic       d_in_pkt;
    logic [1:0] d_route;
    int         d_cnt;

    always #5 clk = ~clk;

    packet_demux #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .up_sel     (up_sel),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_last  (down_last),
        .busy       (busy),
        .drop_count (drop_count)
    );

    packet_demux #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(4)) u_drop (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (d_valid),
        .up_ready   (d_ready),
        .up_data    (d_data),
        .up_last    (d_last),
        .up_sel     (d_sel),
        .down_valid (d_down_valid),
        .down_ready (d_down_ready),
        .down_data  (d_down_data),
        .down_last  (d_down_last),
        .busy       (d_busy),
        .drop_count (d_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_head(input int p);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].port == p) return i;
        end
        return -1;
    endfunction

    // One clock: evaluate model and DUT at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [1:0] dst;
        logic       exp_rdy;
        int         h;
        @(negedge clk);
        dst     = m_in_pkt ? m_route : up_sel;
        exp_rdy = (find_head(int'(dst)) < 0) || down_ready[dst];
        check("up_ready", {31'b0, up_ready}, {31'b0, exp_rdy});
        check("busy", {31'b0, busy}, {31'b0, m_in_pkt});
        for (int p = 0; p < 4; p++) begin
            h = find_head(p);
            check($sformatf("valid%0d", p), {31'b0, down_valid[p]}, {31'b0, (h >= 0)});
            if (h >= 0 && down_valid[p]) begin
                check($sformatf("data%0d", p), {24'b0, down_data[p*8 +: 8]}, {24'b0, sb[h].data});
                check($sformatf("last%0d", p), {31'b0, down_last[p]}, {31'b0, sb[h].last});
                if (down_ready[p]) begin
                    $display("port %0d out data=0x%02h last=%0b", p, sb[h].data, sb[h].last);
                    sb.delete(h);
                end
            end
        end
        m_acc = up_valid & exp_rdy;
        if (m_acc) begin
            sb.push_back('{int'(dst), up_data, up_last});
            if (!m_in_pkt) m_route = up_sel;
            m_in_pkt = !up_last;
        end

        // Drop instance: every beat sent there goes to an invalid port.
        check("d_valid", {29'b0, d_down_valid}, 32'd0);
        check("d_drop_count", {28'b0, d_drop_count}, d_cnt);
        if (d_valid) begin
            dst = d_in_pkt ? d_route : d_sel;
            check("d_ready", {31'b0, d_ready}, {31'b0, (dst >= 2'd3) ? 1'b1 : 1'b0});
            if (dst >= 2'd3 && d_cnt < 15) d_cnt++;
            if (!d_in_pkt) d_route = d_sel;
            d_in_pkt = !d_last;
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted, with a bounded wait.
    task automatic send(input logic [1:0] sel, input logic [7:0] data, input logic last);
        int tries;
        up_valid = 1'b1;
        up_sel   = sel;
        up_data  = data;
        up_last  = last;
        tries    = 0;
        m_acc    = 1'b0;
        while (!m_acc && tries < 20) begin
            tick();
            tries++;
        end
        if (!m_acc) check("accept_timeout", {31'b0, m_acc}, 32'd1);
        else $display("in  sel=%0d data=0x%02h last=%0b", sel, data, last);
        up_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_last    = 1'b0;
        up_sel     = '0;
        down_ready = 4'hF;
        d_valid    = 1'b0;
        d_data     = '0;
        d_last     = 1'b0;
        d_sel      = '0;
        d_down_ready = 3'b111;
        m_in_pkt = 1'b0;
        m_route  = '0;
        m_acc    = 1'b0;
        d_in_pkt = 1'b0;
        d_route  = '0;
        d_cnt    = 0;

        // Reset state
        #12;
        check("rst_valid", {28'b0, down_valid}, 32'd0);
        check("rst_data", down_data, 32'd0);
        check("rst_last", {28'b0, down_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_drop", {16'b0, drop_count}, 32'd0);
        check("rst_ready", {31'b0, up_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Back-to-back single-beat packets to every port
        for (int k = 0; k < 4; k++) send(2'(k), 8'(8'hA0 + k), 1'b1);
        tick();
        tick();

        // Packet lock: select changes mid-packet are ignored
        send(2'd2, 8'h11, 1'b0);
        send(2'd1, 8'h22, 1'b0);
        send(2'd1, 8'h33, 1'b1);
        tick();
        tick();

        // Backpressure on port 1, then drain and load in the same cycle
        down_ready = 4'b1101;
        send(2'd1, 8'h55, 1'b1);
        up_valid = 1'b1;
        up_sel   = 2'd1;
        up_data  = 8'h66;
        up_last  = 1'b1;
        tick();
        check("bp_stall", {31'b0, m_acc}, 32'd0);
        tick();
        down_ready = 4'b1111;
        tick();
        check("bp_accept", {31'b0, m_acc}, 32'd1);
        up_valid = 1'b0;
        tick();
        tick();

        // Independence: stalled port 0 does not block a packet to port 3
        down_ready = 4'b1110;
        send(2'd0, 8'h99, 1'b1);
        send(2'd3, 8'hBB, 1'b1);
        tick();
        tick();
        down_ready = 4'b1111;
        tick();
        tick();

        // Drop path on the 3-port instance: 4-beat then 13-beat packet to port 3
        d_valid = 1'b1;
        d_sel   = 2'd3;
        for (int b = 0; b < 17; b++) begin
            d_data = 8'(b);
            d_last = (b == 3) || (b == 16);
            tick();
            if (b == 3) check("drop_after4", {28'b0, d_drop_count}, 32'd4);
        end
        d_valid = 1'b0;
        tick();
        check("drop_saturated", {28'b0, d_drop_count}, 32'd15);

        // Reset in the middle of a packet
        send(2'd0, 8'hC1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {28'b0, down_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_drop", {28'b0, d_drop_count}, 32'd0);
        sb.delete();
        m_in_pkt = 1'b0;
        m_route  = '0;
        d_in_pkt = 1'b0;
        d_cnt    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send(2'd1, 8'h77, 1'b1);
        tick();
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_demux.md
# packet_demux

Stream demultiplexer with packet locking and valid/ready handshakes on every side. A single upstream stream carries data beats tagged with a destination select and a last flag; each packet is routed whole to one of N_OUT downstream ports. Each port has its own one-entry output register. It is the receive-side counterpart to the stream multiplexing used to merge sources onto one channel. Packets addressed to a nonexistent port are dropped and counted.

## Interface
- WIDTH, 8, data beat width in bits
- N_OUT, 4, number of downstream ports (2..2**SEL_W)
- SEL_W, 2, select width; 2**SEL_W >= N_OUT required
- CNT_W, 16, drop counter width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- up_valid  input  1  upstream beat valid
- up_ready  output  1  upstream beat accepted when up_valid & up_ready
- up_data  input  WIDTH  beat payload
- up_last  input  1  final beat of packet
- up_sel  input  SEL_W  destination port, sampled on first beat of packet only
- down_valid  output  N_OUT  per-port beat valid
- down_ready  input  N_OUT  per-port consumer ready
- down_data  output  N_OUT*WIDTH  port i payload in bits [i*WIDTH +: WIDTH]
- down_last  output  N_OUT  per-port last flag
- busy  output  1  packet in progress (state ROUTE)
- drop_count  output  CNT_W  beats dropped due to invalid select, saturating

## Operation
- FSM states: IDLE (between packets), ROUTE (mid-packet).
- Destination cur_dst = up_sel in IDLE, route_q in ROUTE.
- IDLE, accepted beat: route_q <= up_sel. Next state is IDLE if up_last=1, else ROUTE.
- ROUTE: up_sel is ignored. On an accepted beat with up_last=1, next state is IDLE.
- Per-port holding register: full[i], data[i], last[i]. down_valid[i] = full[i].
- Valid cur_dst (< N_OUT): up_ready = !full[cur_dst] | down_ready[cur_dst].
  - This is a combinational ready path from down_ready; it is permitted.
- Invalid cur_dst (>= N_OUT): up_ready = 1 and the beat is discarded.
  - drop_count increments by 1 per dropped beat and saturates at 2**CNT_W-1.
  - Packet locking still applies, so the whole packet is dropped.
- Accepted beat to port i loads data[i]/last[i] and sets full[i].
- Simultaneous drain (down_ready[i] & full[i]) and load on port i: the register takes the new beat and full[i] stays 1.
- Drain without load clears full[i].
- Ports drain independently. A stalled port blocks upstream only while it is cur_dst.
- Beat order is preserved per port. No beat is duplicated or lost except on invalid select or reset.
- busy = (state == ROUTE).

## Timing
- Latency: a beat accepted in cycle n is presented as down_valid in cycle n+1.
- Throughput: 1 beat/cycle per port when down_ready is held high.
- down_data and down_last are stable while down_valid=1 and down_ready=0.
- Reset (rst_n low, effective immediately, no clock needed):
  - state=IDLE, route_q=0, full=0
  - down_valid=0, down_data=0, down_last=0, drop_count=0, busy=0
  - up_ready then reflects the empty registers, i.e. 1 for any select.
- Reset mid-packet aborts the packet: held beats and the remaining route are lost. The first beat after release is treated as a packet start.
- Back-to-back packets: a single-beat packet in cycle n, then a new up_sel in cycle n+1, routes to the new port with no bubble.

## Test plan
- Single-beat packets, all down_ready=1: sel=0..3, data 0xA0..0xA3, last=1 -> port k shows 0xA0+k with down_last=1 one cycle after acceptance; other ports down_valid=0; busy stays 0.
- Packet lock: 3-beat packet, sel=2 on beat 1, sel=1 on beats 2-3, data 0x11/0x22/0x33 -> all three on port 2 in order; busy=1 after beat 1, 0 after beat 3; port 1 never valid.
- Backpressure: down_ready[1]=0, send 0x55 then 0x66 to port 1.
  - 0x55 held, up_ready=0 on 0x66.
  - Raise down_ready[1]: 0x55 drains and 0x66 loads in the same cycle, with down_valid[1] continuously 1.
- Independence: port 0 full and stalled; single-beat packet to port 3 is accepted and appears on port 3 next cycle; port 0 holds its data unchanged.
- Drop: N_OUT=3, CNT_W=4, sel=3 packet of 4 beats -> up_ready=1 each beat, no down_valid, drop_count=4. A further 13 dropped beats -> drop_count=15 (saturated).
- Reset mid-packet: 3-beat packet to port 0, rst_n low after beat 1 -> down_valid=0, busy=0 immediately. After release, single-beat packet sel=1 data 0x77 -> appears on port 1 only.
